// File: rtl/shock_sound_multi.sv
// ---------------------------------------------------------------------------
// shock_sound_multi
//
// Watches NCH asynchronous shock inputs. Each input is synchronised and
// edge-detected. An accepted shock plays a square-wave tone burst whose pitch
// identifies the channel, followed by a silent re-arm gap. Arbitration is
// fixed-priority (lowest index wins). A lower-index shock preempts a playing
// burst. Retrigger is optional. A saturating counter records accepted events.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   en         enable; 0 ignores shocks and aborts a burst or gap
//   retrig     1: repeat shock on the playing channel reloads the duration
//   clr_count  synchronous clear of evt_count (wins over an increment)
//   shock      raw asynchronous shock inputs, one per channel
//   sound      tone output to the buzzer
//   busy       1 while a burst or the re-arm gap is in progress
//   ch_id      channel currently or last played
//   evt_count  accepted-event counter, saturating
// ---------------------------------------------------------------------------
module shock_sound_multi #(
  parameter int NCH       = 4,
  parameter int DURATION  = 100,
  parameter int DUR_W     = 8,
  parameter int HALF_BASE = 2,
  parameter int GAP_CYC   = 4,
  parameter int CNT_W     = 8,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             retrig,
  input  logic             clr_count,
  input  logic [NCH-1:0]   shock,
  output logic             sound,
  output logic             busy,
  output logic [CH_W-1:0]  ch_id,
  output logic [CNT_W-1:0] evt_count
);

  // Tone counter must reach the longest half-period (highest channel);
  // gap counter must hold GAP_CYC-1.
  localparam int TONE_W = $clog2(HALF_BASE * NCH + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  state_t state, state_nxt;

  logic [NCH-1:0]    s1, s2, prev, rise;
  logic [DUR_W-1:0]  dur_cnt, dur_nxt;
  logic [TONE_W-1:0] tone_cnt, tone_nxt, tone_last;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic              sound_q, sound_nxt;
  logic [CH_W-1:0]   ch_q, ch_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic              evt_inc;

  logic [CH_W-1:0]   win, lower_win;
  logic              any_rise, lower_any;
  logic [TONE_W-1:0] tone_step;
  logic              sound_step;

  // Two-flop synchroniser per channel plus a history flop for rising-edge
  // detection. A shock held high across reset release yields one rise
  // because all three stages come out of reset at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= shock;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;

  // Priority encoders: overall winner for IDLE, and the best channel strictly
  // below the playing one for preemption. Scanning downwards leaves the
  // lowest set index as the final assignment.
  always_comb begin
    win       = '0;
    any_rise  = 1'b0;
    lower_win = '0;
    lower_any = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (rise[k]) begin
        win      = CH_W'(k);
        any_rise = 1'b1;
        if (k < int'(ch_q)) begin
          lower_win = CH_W'(k);
          lower_any = 1'b1;
        end
      end
    end
  end

  // One tone step: toggle the output at the end of each half-period of the
  // playing channel, otherwise advance the phase counter.
  assign tone_last = TONE_W'(HALF_BASE * (int'(ch_q) + 1) - 1);

  always_comb begin
    tone_step  = tone_cnt + 1'b1;
    sound_step = sound_q;
    if (tone_cnt == tone_last) begin
      tone_step  = '0;
      sound_step = ~sound_q;
    end
  end

  // State register and datapath registers for the burst/gap sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dur_cnt  <= '0;
      tone_cnt <= '0;
      gap_cnt  <= '0;
      sound_q  <= 1'b0;
      ch_q     <= '0;
    end else begin
      state    <= state_nxt;
      dur_cnt  <= dur_nxt;
      tone_cnt <= tone_nxt;
      gap_cnt  <= gap_nxt;
      sound_q  <= sound_nxt;
      ch_q     <= ch_nxt;
    end
  end

  // Next-state logic. In PLAY the checks run in priority order: disable,
  // preemption by a lower channel, retrigger on the same channel, then the
  // normal tone/duration progression. Rises on other channels, and all rises
  // in GAP, fall through without effect and are not counted.
  always_comb begin
    state_nxt = state;
    dur_nxt   = dur_cnt;
    tone_nxt  = tone_cnt;
    gap_nxt   = gap_cnt;
    sound_nxt = sound_q;
    ch_nxt    = ch_q;
    evt_inc   = 1'b0;

    case (state)
      IDLE: begin
        sound_nxt = 1'b0;
        if (en && any_rise) begin
          state_nxt = PLAY;
          ch_nxt    = win;
          dur_nxt   = DUR_W'(DURATION - 1);
          tone_nxt  = '0;
          sound_nxt = 1'b1;
          evt_inc   = 1'b1;
        end
      end

      PLAY: begin
        if (!en) begin
          state_nxt = IDLE;
          sound_nxt = 1'b0;
        end else if (lower_any) begin
          ch_nxt    = lower_win;
          dur_nxt   = DUR_W'(DURATION - 1);
          tone_nxt  = '0;
          sound_nxt = 1'b1;
          evt_inc   = 1'b1;
        end else if (retrig && rise[ch_q]) begin
          dur_nxt   = DUR_W'(DURATION - 1);
          tone_nxt  = tone_step;
          sound_nxt = sound_step;
          evt_inc   = 1'b1;
        end else if (dur_cnt == '0) begin
          state_nxt = GAP;
          gap_nxt   = GAP_W'(GAP_CYC - 1);
          sound_nxt = 1'b0;
        end else begin
          dur_nxt   = dur_cnt - 1'b1;
          tone_nxt  = tone_step;
          sound_nxt = sound_step;
        end
      end

      GAP: begin
        sound_nxt = 1'b0;
        if (!en || gap_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt - 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        sound_nxt = 1'b0;
      end
    endcase
  end

  // Saturating event counter; a clear on the same edge as an accepted event
  // leaves the counter at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_count) begin
      cnt_q <= '0;
    end else if (evt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Outputs come straight from flops (busy from the state register), so an
  // asynchronous reset drives them all to 0 without a combinational path.
  assign sound     = sound_q;
  assign busy      = (state != IDLE);
  assign ch_id     = ch_q;
  assign evt_count = cnt_q;

endmodule

// File: tb/tb_shock_sound_multi.sv
// ---------------------------------------------------------------------------
// tb_shock_sound_multi
//
// Self-checking bench for shock_sound_multi (NCH=4, DURATION=8, HALF_BASE=2,
// GAP_CYC=4, CNT_W=4). A reference model computes the expected outputs every
// cycle from burst start/end times and tone phase arithmetic and pushes them
// into a queue; a monitor pops and compares on the falling edge. Directed
// scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_shock_sound_multi;

  localparam int NCH       = 4;
  localparam int DURATION  = 8;
  localparam int HALF_BASE = 2;
  localparam int GAP_CYC   = 4;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       sound;
    logic       busy;
    logic [1:0] ch;
    logic [3:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             retrig;
  logic             clr_count;
  logic [NCH-1:0]   shock;
  logic             sound;
  logic             busy;
  logic [1:0]       ch_id;
  logic [CNT_W-1:0] evt_count;

  int checkCount = 0;
  int errorCount = 0;

  exp_t expQueue[$];

  shock_sound_multi #(
    .NCH(NCH),
    .DURATION(DURATION),
    .DUR_W(8),
    .HALF_BASE(HALF_BASE),
    .GAP_CYC(GAP_CYC),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .retrig(retrig),
    .clr_count(clr_count),
    .shock(shock),
    .sound(sound),
    .busy(busy),
    .ch_id(ch_id),
    .evt_count(evt_count)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Reference model state. Bursts are described by the edge they started
  // (tone phase origin) and the last edge that still plays; the gap by its
  // last edge. Mode: 0 idle, 1 play, 2 gap.
  int             edgeNum;
  int             mMode;
  int             mCh;
  int             mPhase;
  int             mLast;
  int             mGapLast;
  int             mCnt;
  logic [NCH-1:0] smp1, smp2, smp3;

  function automatic int halfOf(input int ch);
    return HALF_BASE * (ch + 1);
  endfunction

  // Reference model: at every rising edge apply the behavioural rules to the
  // inputs seen at that edge and queue the outputs expected after it. A rise
  // reaches the sequencer two edges after the shock was first sampled.
  always @(posedge clk) begin
    logic [NCH-1:0] rz;
    exp_t e;
    int lowCh;
    bit inc;
    if (!rst) begin
      edgeNum = 0;
      mMode = 0;
      mCh = 0;
      mPhase = 0;
      mLast = 0;
      mGapLast = 0;
      mCnt = 0;
      smp1 = '0;
      smp2 = '0;
      smp3 = '0;
    end else begin
      edgeNum++;
      rz = smp2 & ~smp3;
      smp3 = smp2;
      smp2 = smp1;
      smp1 = shock;
      inc = 1'b0;
      lowCh = -1;
      for (int k = NCH - 1; k >= 0; k--) if (rz[k]) lowCh = k;
      case (mMode)
        0: begin
          if (en && lowCh >= 0) begin
            mMode = 1; mCh = lowCh; mPhase = edgeNum;
            mLast = edgeNum + DURATION - 1; inc = 1'b1;
          end
        end
        1: begin
          if (!en) begin
            mMode = 0;
          end else if (lowCh >= 0 && lowCh < mCh) begin
            mCh = lowCh; mPhase = edgeNum;
            mLast = edgeNum + DURATION - 1; inc = 1'b1;
          end else if (retrig && rz[mCh]) begin
            mLast = edgeNum + DURATION - 1; inc = 1'b1;
          end else if (edgeNum > mLast) begin
            mMode = 2; mGapLast = edgeNum + GAP_CYC - 1;
          end
        end
        default: begin
          if (!en || edgeNum > mGapLast) mMode = 0;
        end
      endcase
      if (clr_count) mCnt = 0;
      else if (inc && mCnt < CNT_MAX) mCnt++;
    end
    e.sound = (mMode == 1) && ((((edgeNum - mPhase) / halfOf(mCh)) % 2) == 0);
    e.busy  = (mMode != 0);
    e.ch    = 2'(mCh);
    e.cnt   = 4'(mCnt);
    expQueue.push_back(e);
  end

  // Monitor: on each falling edge compare the DUT outputs with the next
  // expected entry produced by the model.
  always @(negedge clk) begin
    exp_t e;
    if (expQueue.size() > 0) begin
      e = expQueue.pop_front();
      checkCount++;
      if (sound !== e.sound || busy !== e.busy || ch_id !== e.ch || evt_count !== e.cnt) begin
        errorCount++;
        $display("[TB] FAIL cycle_compare at %0t: got sound=%0b busy=%0b ch_id=%0d evt_count=%0d, expected sound=%0b busy=%0b ch_id=%0d evt_count=%0d",
                 $time, sound, busy, ch_id, evt_count, e.sound, e.busy, e.ch, e.cnt);
      end
    end
  end

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] sh, input logic e, input logic r, input logic c);
    @(negedge clk);
    #2;
    shock     = sh;
    en        = e;
    retrig    = r;
    clr_count = c;
  endtask

  task automatic setShock(input logic [NCH-1:0] sh);
    @(negedge clk);
    #2;
    shock = sh;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int ch);
    setShock(NCH'(1) << ch);
    setShock(NCH'(1) << ch);
    setShock('0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2;
    rst = 1'b0; shock = '0; en = 1'b1; retrig = 1'b0; clr_count = 1'b0;
    waitCycles(2);
    #2;
    rst = 1'b1;
  endtask

  // Main stimulus: directed scenarios, then randomized traffic.
  initial begin
    rst = 1'b0; shock = '0; en = 1'b1; retrig = 1'b0; clr_count = 1'b0;
    waitCycles(2);
    checkOutput("reset_busy", 8'(busy), 8'd0);
    checkOutput("reset_count", 8'(evt_count), 8'd0);
    #2 rst = 1'b1;

    // Single bursts on channel 0 and channel 2.
    pulse(0);
    waitCycles(20);
    checkOutput("ch0_count", 8'(evt_count), 8'd1);
    checkOutput("ch0_id", 8'(ch_id), 8'd0);
    checkOutput("ch0_idle", 8'(busy), 8'd0);
    pulse(2);
    waitCycles(25);
    checkOutput("ch2_id", 8'(ch_id), 8'd2);
    checkOutput("ch2_count", 8'(evt_count), 8'd2);

    // Preemption by a lower channel; a higher channel is then ignored.
    resetDut();
    pulse(3);
    waitCycles(2);
    pulse(1);
    pulse(3);
    waitCycles(25);
    checkOutput("preempt_id", 8'(ch_id), 8'd1);
    checkOutput("preempt_count", 8'(evt_count), 8'd2);

    // Retrigger enabled, then disabled.
    resetDut();
    applyStimulus('0, 1'b1, 1'b1, 1'b0);
    pulse(0);
    waitCycles(1);
    pulse(0);
    waitCycles(30);
    checkOutput("retrig_on_count", 8'(evt_count), 8'd2);
    resetDut();
    pulse(0);
    waitCycles(1);
    pulse(0);
    waitCycles(30);
    checkOutput("retrig_off_count", 8'(evt_count), 8'd1);

    // Shock during the gap, saturation, clear against an accepted event.
    resetDut();
    pulse(0);
    waitCycles(6);
    setShock(4'b0010);
    setShock('0);
    waitCycles(20);
    checkOutput("gap_ignored_count", 8'(evt_count), 8'd1);
    for (int i = 0; i < 17; i++) begin
      pulse(i % NCH);
      waitCycles(14);
    end
    checkOutput("saturated_count", 8'(evt_count), 8'd15);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1);
    applyStimulus('0, 1'b1, 1'b0, 1'b1);
    applyStimulus('0, 1'b1, 1'b0, 1'b1);
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_wins_count", 8'(evt_count), 8'd0);
    checkOutput("clear_wins_busy", 8'(busy), 8'd1);
    waitCycles(20);

    // Asynchronous reset mid-burst, shock held through release, en abort.
    pulse(0);
    waitCycles(3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    shock = 4'b0001;
    #1;
    checkOutput("async_rst_sound", 8'(sound), 8'd0);
    checkOutput("async_rst_busy", 8'(busy), 8'd0);
    checkOutput("async_rst_count", 8'(evt_count), 8'd0);
    waitCycles(2);
    #2 rst = 1'b1;
    waitCycles(25);
    checkOutput("held_shock_count", 8'(evt_count), 8'd1);
    setShock('0);
    waitCycles(3);
    pulse(1);
    waitCycles(3);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("en_abort_busy", 8'(busy), 8'd0);
    checkOutput("en_abort_sound", 8'(sound), 8'd0);
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    waitCycles(5);

    // Randomized traffic: sparse shock toggles, occasional disable, clear,
    // retrigger changes and rare resets.
    for (int i = 0; i < 1500; i++) begin
      logic [NCH-1:0] nxt;
      nxt = shock;
      for (int k = 0; k < NCH; k++) if ($urandom_range(0, 9) == 0) nxt[k] = ~nxt[k];
      @(negedge clk);
      #2;
      shock     = nxt;
      en        = ($urandom_range(0, 59) != 0);
      clr_count = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) retrig = ~retrig;
      rst       = ($urandom_range(0, 399) != 0);
    end
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b1;
    waitCycles(30);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
